kred_butterfly_pipe: RTL and testbench
======================================

Name: kred_butterfly_pipe

Overview:
Parametrised, fully pipelined NTT/INTT butterfly built around K-RED modular reduction for any prime q = K*2^M + 1. It is the successor of the Falcon-only K-RED butterfly: one RTL covers Falcon (q=12289) and Kyber (q=3329). It adds a valid/ready stream interface with backpressure, a per-beat mode select and tag passthrough. It sits between the coefficient RAM read ports and the write-back path of the NTT engine.

Parameters:
DW, 14, coefficient width; requires 2^DW > q
K, 3, K-RED constant; Falcon = 3, Kyber = 13
M, 12, K-RED shift; Falcon = 12, Kyber = 8
Q, 12289, modulus; must equal K*2^M+1 (elaboration-time check, $error on mismatch)
TAG_W, 10, width of the sideband tag (coefficient address)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
mode  in  2  00 = CT, 01 = GS, 10 = PWM, 11 = reserved (treated as CT)
a  in  DW  operand A, range [0,Q)
b  in  DW  operand B, range [0,Q)
w  in  DW  twiddle, pre-scaled by K^-1 mod Q
tag_in  in  TAG_W  sideband, travels with the beat
out_valid  out  1  result valid
out_ready  in  1  downstream accepts when out_valid && out_ready
e  out  DW  even output, range [0,Q)
o  out  DW  odd output, range [0,Q)
tag_out  out  TAG_W  tag of the beat in e/o

Behaviour:
- Arithmetic: t = kred(x*y) = (K*x*y) mod Q, reduced exactly to [0,Q) for all x, y < Q.
- Reduction: K-RED on the 2*DW-bit product (C_l = C[M-1:0], C_h = C>>M, r = K*C_l - C_h, signed), followed by final correction to [0,Q).
- CT: t = kred(b*w); e = (a+t) mod Q; o = (a-t) mod Q.
- GS: e = ((a+b) mod Q)/2 mod Q; o = kred(((a-b) mod Q)*w)/2 mod Q.
- PWM: o = kred(a*b), with w ignored; e = (a+b) mod Q.
- Halving: x/2 = x>>1 if x is even, else (x>>1) + (Q+1)/2.
- Pipeline has 4 stages:
  - S1 registers operands and mode, and computes the GS pre-sub.
  - S2 multiplies.
  - S3 does K-RED and correction.
  - S4 does the post add/sub/halve.
- Latency: an accepted beat appears on out_valid exactly 4 cycles later when there is no stall.
- Throughput: 1 beat per cycle.
- Backpressure is a global stall: in_ready = !out_valid || out_ready. When in_ready is 0, every stage register holds.
- Bubbles are allowed: the valid bit travels per stage and empty stages carry no result.
- mode is sampled per beat, so consecutive beats may use different modes with no flush.
- Ordering: beats leave strictly in acceptance order; tag_out is the tag_in of the same beat.
- While out_valid=1 and out_ready=0, e, o and tag_out hold stable.
- Reset: all stage valid bits clear; out_valid=0; e, o and tag_out = 0; in_ready=1 in the cycle after rst is deasserted.
- Reset asserted mid-stream discards all in-flight beats, and none appear afterwards.
- Input values >= Q are illegal and their outputs are undefined. An assertion fires in simulation.

Optional Feature:
Macro BFLY_STATS_EN.
- When defined:
  - Adds outputs mul_cnt, add_cnt and sub_cnt, each 32 bits.
  - Each counts the modular multiplies, adds and subtracts performed by beats leaving S4 (out_valid && out_ready).
  - Per beat:
    - CT: +1 mul, +1 add, +1 sub.
    - GS: +1 mul, +1 add, +1 sub.
    - PWM: +1 mul, +1 add.
  - Counters clear on rst, wrap at 2^32 and do not advance during a stall.
- When undefined: these ports and their logic do not exist.

Test Plan:
- Falcon CT: a=12288, b=1, w=8193 (twiddle 1 times 3^-1) -> 4 cycles later e=0, o=12287.
- Falcon GS: a=5, b=2, w=8193 -> e=6148, o=6146. Falcon PWM: a=2, b=3 -> o=18, e=5.
- Kyber config (DW=12, K=13, M=8, Q=3329), CT: a=0, b=100, w=3073 -> e=100, o=3229.
- Backpressure: issue 6 back-to-back beats with tags 0..5 and hold out_ready=0 for 3 cycles after the first out_valid.
  - in_ready drops during the stall.
  - All 6 results emerge in tag order with correct values.
  - Outputs are stable while stalled.
- Reset: assert rst for 1 cycle while 3 beats are in flight -> out_valid stays 0 and no stale beat emerges; the next beat appears after exactly 4 cycles.
- Random sweep: 10k beats in each mode with random a, b, w < Q and random out_ready, against the model (K*x*y) mod Q. Zero mismatches are required, and with BFLY_STATS_EN the counters must match the model totals.

Source files
------------

// File: rtl/kred_butterfly_pipe.sv
`default_nettype none
// ============================================================================
// Module  : kred_butterfly_pipe
// Brief   : 4-stage CT/GS/PWM butterfly with K-RED reduction, q = K*2^M + 1.
//           Optional macro BFLY_STATS_EN adds modular-op counters.
// Revision: 1.0
// ============================================================================
module kred_butterfly_pipe #(
  parameter int DW    = 14,
  parameter int K     = 3,
  parameter int M     = 12,
  parameter int Q     = 12289,
  parameter int TAG_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  input  logic [DW-1:0]    w,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    e,
  output logic [DW-1:0]    o,
  output logic [TAG_W-1:0] tag_out
`ifdef BFLY_STATS_EN
  ,
  output logic [31:0]      mul_cnt,
  output logic [31:0]      add_cnt,
  output logic [31:0]      sub_cnt
`endif
);

  localparam int PW = 2 * DW;
  localparam int RW = PW + 2;
  localparam int SH = $clog2(K + 1);
  localparam logic [DW-1:0] C_Q    = DW'(Q);
  localparam logic [DW-1:0] C_HALF = DW'((Q + 1) / 2);
  localparam logic [RW-1:0] C_QR   = RW'(Q);
  localparam logic [RW-1:0] C_KQ   = RW'(K * Q);
  localparam logic [1:0] MODE_GS  = 2'b01;
  localparam logic [1:0] MODE_PWM = 2'b10;

  generate
    if (Q != K * (2 ** M) + 1) begin : g_bad_q
      $error("kred_butterfly_pipe: Q must equal K*2^M+1");
    end
    if ((2 ** DW) <= Q) begin : g_bad_dw
      $error("kred_butterfly_pipe: 2^DW must exceed Q");
    end
  endgenerate

  function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, C_Q}) s = s - {1'b0, C_Q};
    return s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] x, input logic [DW-1:0] y);
    if (x >= y) return x - y;
    return x + (C_Q - y);
  endfunction

  function automatic logic [DW-1:0] mod_half(input logic [DW-1:0] x);
    if (x[0]) return (x >> 1) + C_HALF;
    return x >> 1;
  endfunction

  // Stage registers
  logic             r1_v, r2_v, r3_v;
  logic [1:0]       r1_mode, r2_mode, r3_mode;
  logic [DW-1:0]    r1_a, r1_b, r1_x, r1_y, r2_a, r2_b, r3_a, r3_b, r3_t;
  logic [PW-1:0]    r2_p;
  logic [TAG_W-1:0] r1_tag, r2_tag, r3_tag;

  logic [DW-1:0]    w_x, w_y, w_t, w_e, w_o;
  logic [M-1:0]     w_cl;
  logic [PW-M-1:0]  w_ch;
  logic [RW-1:0]    w_red;

  assign in_ready = !out_valid || out_ready;

  // S1 operand steering: GS multiplies the difference, PWM multiplies a*b
  always_comb begin
    w_x = b;
    w_y = w;
    case (mode)
      MODE_GS:  w_x = mod_sub(a, b);
      MODE_PWM: begin
        w_x = a;
        w_y = b;
      end
      default: ;
    endcase
  end

  assign w_cl = r2_p[M-1:0];
  assign w_ch = r2_p[PW-1:M];

  // K*Q bias keeps K*C_l - C_h non-negative; restoring subtraction then lands in [0,Q)
  always_comb begin
    w_red = RW'(K) * RW'(w_cl) + C_KQ - RW'(w_ch);
    for (int i = SH; i >= 0; i--) begin
      if (w_red >= (C_QR << i)) w_red = w_red - (C_QR << i);
    end
  end

  assign w_t = w_red[DW-1:0];

  always_comb begin
    w_e = mod_add(r3_a, r3_t);
    w_o = mod_sub(r3_a, r3_t);
    case (r3_mode)
      MODE_GS: begin
        w_e = mod_half(mod_add(r3_a, r3_b));
        w_o = mod_half(r3_t);
      end
      MODE_PWM: begin
        w_e = mod_add(r3_a, r3_b);
        w_o = r3_t;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_v      <= 1'b0;
      r2_v      <= 1'b0;
      r3_v      <= 1'b0;
      out_valid <= 1'b0;
      r1_mode   <= '0;
      r2_mode   <= '0;
      r3_mode   <= '0;
      r1_a      <= '0;
      r1_b      <= '0;
      r1_x      <= '0;
      r1_y      <= '0;
      r2_a      <= '0;
      r2_b      <= '0;
      r2_p      <= '0;
      r3_a      <= '0;
      r3_b      <= '0;
      r3_t      <= '0;
      r1_tag    <= '0;
      r2_tag    <= '0;
      r3_tag    <= '0;
      e         <= '0;
      o         <= '0;
      tag_out   <= '0;
    end else if (in_ready) begin
      r1_v      <= in_valid;
      r1_mode   <= mode;
      r1_a      <= a;
      r1_b      <= b;
      r1_x      <= w_x;
      r1_y      <= w_y;
      r1_tag    <= tag_in;

      r2_v      <= r1_v;
      r2_mode   <= r1_mode;
      r2_a      <= r1_a;
      r2_b      <= r1_b;
      r2_p      <= PW'(r1_x) * PW'(r1_y);
      r2_tag    <= r1_tag;

      r3_v      <= r2_v;
      r3_mode   <= r2_mode;
      r3_a      <= r2_a;
      r3_b      <= r2_b;
      r3_t      <= w_t;
      r3_tag    <= r2_tag;

      out_valid <= r3_v;
      e         <= w_e;
      o         <= w_o;
      tag_out   <= r3_tag;
    end
  end

`ifdef BFLY_STATS_EN
  logic [1:0] r4_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      r4_mode <= '0;
      mul_cnt <= '0;
      add_cnt <= '0;
      sub_cnt <= '0;
    end else begin
      if (in_ready) r4_mode <= r3_mode;
      if (out_valid && out_ready) begin
        mul_cnt <= mul_cnt + 32'd1;
        add_cnt <= add_cnt + 32'd1;
        if (r4_mode != MODE_PWM) sub_cnt <= sub_cnt + 32'd1;
      end
    end
  end
`endif

  a_in_range: assert property (@(posedge clk) disable iff (rst)
    (in_valid && in_ready) |-> (a < C_Q && b < C_Q && w < C_Q))
    else $error("kred_butterfly_pipe: operand >= Q");

endmodule
`default_nettype wire

// File: tb/tb_kred_butterfly_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_kred_butterfly_pipe
// Brief   : Vector table, stall/reset sequences and random sweep for the butterfly.
// Revision: 1.0
// ============================================================================
module tb_kred_butterfly_pipe;

  localparam int FDW = 14, FK = 3, FM = 12, FQ = 12289, TW = 10;
  localparam int KDW = 12, KK = 13, KM = 8, KQ = 3329;

  logic clk, rst;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [1:0] mode;
  logic [FDW-1:0] a, b, w, e, o;
  logic [TW-1:0] tag_in, tag_out;

  logic k_in_valid, k_in_ready, k_out_valid, k_out_ready;
  logic [1:0] k_mode;
  logic [KDW-1:0] k_a, k_b, k_w, k_e, k_o;
  logic [TW-1:0] k_tag_in, k_tag_out;

`ifdef BFLY_STATS_EN
  logic [31:0] mul_cnt, add_cnt, sub_cnt, k_mul_cnt, k_add_cnt, k_sub_cnt;
`endif

  kred_butterfly_pipe #(.DW(FDW), .K(FK), .M(FM), .Q(FQ), .TAG_W(TW)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .a(a), .b(b), .w(w), .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
`ifdef BFLY_STATS_EN
    .mul_cnt(mul_cnt), .add_cnt(add_cnt), .sub_cnt(sub_cnt),
`endif
    .e(e), .o(o), .tag_out(tag_out)
  );

  kred_butterfly_pipe #(.DW(KDW), .K(KK), .M(KM), .Q(KQ), .TAG_W(TW)) u_kyb (
    .clk(clk), .rst(rst), .in_valid(k_in_valid), .in_ready(k_in_ready), .mode(k_mode),
    .a(k_a), .b(k_b), .w(k_w), .tag_in(k_tag_in), .out_valid(k_out_valid),
    .out_ready(k_out_ready),
`ifdef BFLY_STATS_EN
    .mul_cnt(k_mul_cnt), .add_cnt(k_add_cnt), .sub_cnt(k_sub_cnt),
`endif
    .e(k_e), .o(k_o), .tag_out(k_tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] md;
    int e;
    int o;
    int tag;
  } exp_t;

  typedef struct {
    logic [1:0] md;
    int a, b, w, tag, e, o;
  } vec_t;

  exp_t sb[$];
  exp_t mon_x;
  vec_t vecs[8];
  int checks = 0;
  int errors = 0;
  int unsigned exp_mul = 0, exp_add = 0, exp_sub = 0;
  bit rand_rdy = 1'b0;

  task automatic check(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  function automatic int kmul(input int x, input int y);
    longint p;
    p = longint'(FK) * longint'(x) * longint'(y);
    return int'(p % FQ);
  endfunction

  function automatic int halve(input int x);
    return (x % 2 == 0) ? x / 2 : (x + FQ) / 2;
  endfunction

  task automatic send(input logic [1:0] md, input int av, input int bv, input int wv,
                      input int tg, input int ee, input int eo);
    int n;
    exp_t x;
    mode = md; a = FDW'(av); b = FDW'(bv); w = FDW'(wv); tag_in = TW'(tg);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready 0 for %0d cycles, required 1", n);
    end else begin
      x.md = md; x.e = ee; x.o = eo; x.tag = tg;
      sb.push_back(x);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0; w = '0;
  endtask

  task automatic send_model(input logic [1:0] md, input int av, input int bv,
                            input int wv, input int tg);
    int ee, eo, t;
    case (md)
      2'b01: begin
        ee = halve((av + bv) % FQ);
        eo = halve(kmul((av - bv + FQ) % FQ, wv));
      end
      2'b10: begin
        ee = (av + bv) % FQ;
        eo = kmul(av, bv);
      end
      default: begin
        t  = kmul(bv, wv);
        ee = (av + t) % FQ;
        eo = (av - t + FQ) % FQ;
      end
    endcase
    send(md, av, bv, wv, tg, ee, eo);
  endtask

  task automatic latency_check(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check(nm, n, 4);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_size", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // Scoreboard: one pop per output handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat: got tag %0d, required no beat", tag_out);
      end else begin
        mon_x = sb.pop_front();
        check("beat_e", e, mon_x.e);
        check("beat_o", o, mon_x.o);
        check("beat_tag", tag_out, mon_x.tag);
        exp_mul++;
        exp_add++;
        if (mon_x.md != 2'b10) exp_sub++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int n, viol;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = '0;
    a = '0; b = '0; w = '0; tag_in = '0;
    k_in_valid = 1'b0; k_out_ready = 1'b1; k_mode = '0;
    k_a = '0; k_b = '0; k_w = '0; k_tag_in = '0;

    vecs[0] = '{2'b00, 12288, 1,     8193,  1, 0,     12287};
    vecs[1] = '{2'b01, 5,     2,     8193,  2, 6148,  6146};
    vecs[2] = '{2'b10, 2,     3,     0,     3, 5,     18};
    vecs[3] = '{2'b00, 0,     0,     5,     4, 0,     0};
    vecs[4] = '{2'b11, 12288, 1,     8193,  5, 0,     12287};
    vecs[5] = '{2'b10, 12288, 12288, 777,   6, 12287, 3};
    vecs[6] = '{2'b01, 0,     1,     8193,  7, 6145,  6144};
    vecs[7] = '{2'b00, 12288, 12288, 12288, 8, 2,     12285};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_e", e, 0);
    check("rst_o", o, 0);
    check("rst_tag_out", tag_out, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Fixed vectors; first one also measures latency
    send(vecs[0].md, vecs[0].a, vecs[0].b, vecs[0].w, vecs[0].tag, vecs[0].e, vecs[0].o);
    latency_check("latency_first");
    @(posedge clk); #1;
    for (int i = 1; i < 8; i++)
      send(vecs[i].md, vecs[i].a, vecs[i].b, vecs[i].w, vecs[i].tag, vecs[i].e, vecs[i].o);
    drain();

    // Kyber instance
    k_mode = 2'b00; k_a = 12'd0; k_b = 12'd100; k_w = 12'd3073; k_in_valid = 1'b1;
    @(posedge clk); #1;
    k_in_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!k_out_valid && n < 20);
    check("kyber_ct_latency", n, 4);
    check("kyber_ct_e", k_e, 100);
    check("kyber_ct_o", k_o, 3229);
    @(posedge clk); #1;
    k_mode = 2'b10; k_a = 12'd3328; k_b = 12'd3328; k_w = 12'd0; k_in_valid = 1'b1;
    @(posedge clk); #1;
    k_in_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!k_out_valid && n < 20);
    check("kyber_pwm_e", k_e, 3327);
    check("kyber_pwm_o", k_o, 13);
    @(posedge clk); #1;

    // Backpressure: 3-cycle stall starting at the first out_valid
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send_model(2'(i % 3), int'($urandom_range(0, FQ - 1)),
                     int'($urandom_range(0, FQ - 1)), int'($urandom_range(0, FQ - 1)), i);
      end
      begin
        int m;
        m = 0;
        while (!out_valid && m < 50) begin
          @(posedge clk); #1;
          m++;
        end
        check("bp_first_valid_seen", out_valid, 1);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready_low", in_ready, 0);
          check("bp_hold_valid", out_valid, 1);
          check("bp_hold_e", e, sb[0].e);
          check("bp_hold_o", o, sb[0].o);
          check("bp_hold_tag", tag_out, sb[0].tag);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with 3 beats in flight
    for (int i = 0; i < 3; i++) send_model(2'b00, 100 + i, 200 + i, 8193, 20 + i);
    rst = 1'b1;
    sb.delete();
    exp_mul = 0; exp_add = 0; exp_sub = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);
    viol = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) viol++;
    end
    check("no_stale_beat_cycles", viol, 0);
    @(posedge clk); #1;
    send_model(2'b01, 5, 2, 8193, 30);
    latency_check("latency_after_rst");
    drain();

    // Random sweep with random backpressure
    rand_rdy = 1'b1;
    for (int md = 0; md < 3; md++) begin
      for (int i = 0; i < 10000; i++)
        send_model(2'(md), int'($urandom_range(0, FQ - 1)), int'($urandom_range(0, FQ - 1)),
                   int'($urandom_range(0, FQ - 1)), i % 1024);
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

`ifdef BFLY_STATS_EN
    check("mul_cnt", mul_cnt, exp_mul);
    check("add_cnt", add_cnt, exp_add);
    check("sub_cnt", sub_cnt, exp_sub);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
